// File: rtl/link_turnaround_ctrl.sv
// link_turnaround_ctrl: USB link-layer phase tracker driving bus direction, engine enables and response timeout
module link_turnaround_ctrl #(
   parameter int TIMER_W  = 16,
   parameter int DELAY_W  = 6,
   parameter int TO_CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rx_pid_en,
   input  logic [3:0]          rx_pid,
   input  logic                rx_sop_en,
   input  logic                rx_eop_en,
   input  logic                tx_pid_en,
   input  logic [3:0]          tx_pid,
   input  logic                tx_eop_en,
   input  logic                ms,
   input  logic [TIMER_W-1:0]  time_threshold,
   input  logic [DELAY_W-1:0]  delay_threshold,
   input  logic                timeout_clr,
   output logic                rx_data_on,
   output logic                rx_handshake_on,
   output logic                tx_data_on,
   output logic                d_oe,
   output logic                time_out,
   output logic [TO_CNT_W-1:0] timeout_cnt,
   output logic                busy
);
   typedef enum logic [2:0] {IDLE, TX, TURN, RX_WAIT, RX} state_t;
   typedef struct packed {
      state_t st;
      logic   nt;
      logic   hs;
   } route_t;
   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   state_t               state, state_n;
   logic [3:0]           pid_q, pid_n;
   logic                 exp_hs, exp_hs_n, next_tx, next_tx_n;
   logic                 expire, done, rx_st, rx_hs;
   logic [DELAY_W-1:0]   dly_cnt, dly_last;
   logic [TIMER_W-1:0]   timer;
   route_t               r;

   function automatic route_t route(input logic tx, input logic [3:0] pid);
      logic data;
      data = pid == PID_DATA0 || pid == PID_DATA1;
      route = '{st: IDLE, nt: 1'b0, hs: 1'b0};
      if (pid == PID_OUT || pid == PID_SETUP)
         route.st = tx ? TX : RX_WAIT;
      else if (pid == PID_IN || data) begin
         route.st = TURN;
         route.nt = !tx;
         route.hs = tx && data;
      end
   endfunction

   assign rx_st    = state == RX_WAIT || state == RX;
   assign rx_hs    = rx_pid_en && (rx_pid == PID_ACK || rx_pid == PID_NAK || rx_pid == PID_STALL);
   assign pid_n    = state == IDLE ? (ms && tx_pid_en ? tx_pid : !ms && rx_pid_en ? rx_pid : pid_q)
                   : state == TX && tx_pid_en ? tx_pid
                   : rx_st && rx_pid_en ? rx_pid : pid_q;
   assign done     = (state == TX && tx_eop_en) || (rx_st && rx_hs) || (state == RX && rx_eop_en);
   assign r        = route(state == TX, pid_n);
   assign dly_last = delay_threshold == '0 ? '0 : delay_threshold - 1'b1;
   assign expire   = state == RX_WAIT && !rx_pid_en && !rx_sop_en && time_threshold != '0
                     && timer == time_threshold - 1'b1;

   assign busy            = state != IDLE;
   assign tx_data_on      = state == TX;
   assign d_oe            = state == TX || (state == IDLE && ms);
   assign rx_data_on      = (state == IDLE && !ms) || (rx_st && !exp_hs);
   assign rx_handshake_on = (state == IDLE && !ms) || (rx_st && exp_hs);

   // next state: packet completion first, then expiry, then phase entry and turnaround exit
   always_comb begin
      state_n   = state;
      next_tx_n = next_tx;
      exp_hs_n  = exp_hs;
      if (done) begin
         state_n   = r.st;
         next_tx_n = r.nt;
         exp_hs_n  = r.hs;
      end else if (expire) begin
         state_n  = IDLE;
         exp_hs_n = 1'b0;
      end else if (state == IDLE && (ms ? tx_pid_en : rx_pid_en))
         state_n = ms ? TX : RX;
      else if (rx_st && (rx_pid_en || rx_sop_en))
         state_n = RX;
      else if (state == TURN && dly_cnt == dly_last)
         state_n = next_tx ? TX : RX_WAIT;
   end

   // state, phase counters and sticky timeout bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pid_q       <= '0;
         exp_hs      <= 1'b0;
         next_tx     <= 1'b0;
         dly_cnt     <= '0;
         timer       <= '0;
         time_out    <= 1'b0;
         timeout_cnt <= '0;
      end else begin
         state       <= state_n;
         pid_q       <= pid_n;
         exp_hs      <= exp_hs_n;
         next_tx     <= next_tx_n;
         dly_cnt     <= state == TURN ? dly_cnt + 1'b1 : '0;
         timer       <= state == RX_WAIT ? timer + 1'b1 : '0;
         time_out    <= expire || (time_out && !timeout_clr);
         timeout_cnt <= expire ? (timeout_clr ? TO_CNT_W'(1) : &timeout_cnt ? timeout_cnt : timeout_cnt + 1'b1)
                      : timeout_clr ? '0 : timeout_cnt;
      end
   end
endmodule

// File: tb/tb_link_turnaround_ctrl.sv
// tb_link_turnaround_ctrl: scoreboard bench for the link turnaround controller
module tb_link_turnaround_ctrl;
   localparam logic [3:0] PID_OUT = 4'b0001, PID_IN = 4'b1001, PID_DATA0 = 4'b0011, PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK = 4'b0010, PID_NAK = 4'b1010;
   localparam logic [4:0] M_IDLE = 5'b01000, S_IDLE = 5'b00011, TXS = 5'b11100;
   localparam logic [4:0] TRN = 5'b10000, RXD = 5'b10010, RXH = 5'b10001;

   logic        clk, rst, rx_pid_en, rx_sop_en, rx_eop_en, tx_pid_en, tx_eop_en, ms, timeout_clr;
   logic [3:0]  rx_pid, tx_pid;
   logic [15:0] time_threshold;
   logic [5:0]  delay_threshold;
   logic        rx_data_on, rx_handshake_on, tx_data_on, d_oe, time_out, busy;
   logic [1:0]  timeout_cnt;
   logic [7:0]  obs;
   logic [2:0]  fl;
   string       tag_q[$];
   logic [7:0]  exp_q[$];
   int          n_run, n_fail;

   link_turnaround_ctrl #(.TIMER_W(16), .DELAY_W(6), .TO_CNT_W(2)) dut (
      .clk(clk), .rst(rst), .rx_pid_en(rx_pid_en), .rx_pid(rx_pid), .rx_sop_en(rx_sop_en),
      .rx_eop_en(rx_eop_en), .tx_pid_en(tx_pid_en), .tx_pid(tx_pid), .tx_eop_en(tx_eop_en),
      .ms(ms), .time_threshold(time_threshold), .delay_threshold(delay_threshold),
      .timeout_clr(timeout_clr), .rx_data_on(rx_data_on), .rx_handshake_on(rx_handshake_on),
      .tx_data_on(tx_data_on), .d_oe(d_oe), .time_out(time_out), .timeout_cnt(timeout_cnt), .busy(busy)
   );

   assign obs = {busy, d_oe, tx_data_on, rx_data_on, rx_handshake_on, time_out, timeout_cnt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_run++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b want %b (busy,d_oe,tx_on,rx_data,rx_hs,time_out,cnt)", tag, got, want);
      end
   endtask

   task automatic cyc(input string tag, input logic [4:0] st);
      tag_q.push_back(tag);
      exp_q.push_back({st, fl});
      @(posedge clk);
      #1;
      {rx_pid_en, rx_sop_en, rx_eop_en, tx_pid_en, tx_eop_en, timeout_clr} = '0;
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
   endtask

   task automatic in_to_rxw();
      tx_pid_en = 1'b1;
      tx_pid = PID_IN;
      cyc("in_pid", TXS);
      tx_eop_en = 1'b1;
      cyc("in_eop", TRN);
      repeat (3) cyc("in_turn", TRN);
      cyc("in_rx_wait", RXD);
   endtask

   task automatic in_timeout(input logic clr);
      in_to_rxw();
      repeat (9) cyc("to_wait", RXD);
      fl = clr ? 3'b101 : {1'b1, fl[1:0] == 2'd3 ? 2'd3 : fl[1:0] + 2'd1};
      timeout_clr = clr;
      cyc("to_expire", M_IDLE);
   endtask

   initial begin
      n_run = 0;
      n_fail = 0;
      fl = 3'b000;
      {rx_pid_en, rx_sop_en, rx_eop_en, tx_pid_en, tx_eop_en, timeout_clr} = '0;
      rx_pid = '0;
      tx_pid = '0;
      rst = 1'b1;
      ms = 1'b1;
      delay_threshold = 6'd4;
      time_threshold = 16'd10;
      cyc("reset", M_IDLE);
      rst = 1'b0;
      ms = 1'b0;
      cyc("slave_idle", S_IDLE);
      tx_pid_en = 1'b1;
      tx_pid = PID_OUT;
      cyc("slave_ignores_tx", S_IDLE);
      ms = 1'b1;
      cyc("master_idle", M_IDLE);
      tx_pid_en = 1'b1;
      tx_pid = PID_OUT;
      cyc("out_pid", TXS);
      tx_eop_en = 1'b1;
      cyc("out_eop", TXS);
      tx_pid_en = 1'b1;
      tx_pid = PID_DATA0;
      cyc("data0_pid", TXS);
      tx_eop_en = 1'b1;
      cyc("data0_eop", TRN);
      repeat (3) cyc("data0_turn", TRN);
      cyc("hs_wait", RXH);
      rx_pid_en = 1'b1;
      rx_pid = PID_ACK;
      cyc("ack_done", M_IDLE);
      in_timeout(1'b0);
      in_to_rxw();
      repeat (9) cyc("sop_wait", RXD);
      rx_sop_en = 1'b1;
      cyc("sop_last_cycle", RXD);
      repeat (12) cyc("sop_rx_hold", RXD);
      rx_pid_en = 1'b1;
      rx_pid = PID_ACK;
      cyc("sop_ack", M_IDLE);
      timeout_clr = 1'b1;
      fl = 3'b000;
      cyc("clr", M_IDLE);
      time_threshold = 16'd0;
      in_to_rxw();
      repeat (1000) @(posedge clk);
      #1;
      cyc("th0_hold", RXD);
      rx_pid_en = 1'b1;
      rx_pid = PID_NAK;
      cyc("th0_nak", M_IDLE);
      time_threshold = 16'd10;
      repeat (5) in_timeout(1'b0);
      in_timeout(1'b1);
      ms = 1'b0;
      rx_pid_en = 1'b1;
      rx_pid = PID_IN;
      cyc("s_in_pid", RXD);
      rx_eop_en = 1'b1;
      cyc("s_in_eop", TRN);
      repeat (3) cyc("s_turn", TRN);
      cyc("s_tx", TXS);
      delay_threshold = 6'd0;
      tx_pid_en = 1'b1;
      tx_pid = PID_DATA1;
      cyc("s_data1_pid", TXS);
      tx_eop_en = 1'b1;
      cyc("s_data1_eop", TRN);
      cyc("s_hs_wait", RXH);
      rx_pid_en = 1'b1;
      rx_pid = PID_NAK;
      cyc("s_nak", S_IDLE);
      delay_threshold = 6'd4;
      ms = 1'b1;
      tx_pid_en = 1'b1;
      tx_pid = PID_IN;
      cyc("r_in_pid", TXS);
      tx_eop_en = 1'b1;
      cyc("r_in_eop", TRN);
      rst = 1'b1;
      fl = 3'b000;
      cyc("rst_in_turn", M_IDLE);
      rst = 1'b0;
      tx_pid_en = 1'b1;
      tx_pid = PID_OUT;
      cyc("ms_out_pid", TXS);
      ms = 1'b0;
      cyc("ms_mid_tx", TXS);
      tx_pid_en = 1'b1;
      tx_pid = PID_ACK;
      tx_eop_en = 1'b1;
      cyc("ms_back_idle", S_IDLE);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
